// File: rtl/clock_divider_prog.sv
// ============================================================================
// Module   : clock_divider_prog
// Brief    : Runtime-programmable 50 % duty divider with boundary-aligned
//            divisor reload and single-cycle Rise/Fall strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clock_divider_prog #(
    parameter int unsigned WIDTH        = 24,
    parameter int unsigned DEFAULT_HALF = 64000
) (
    input  logic             Clk_in,
    input  logic             Rst,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] Half_in,
    output logic             Clk_out,
    output logic             Rise,
    output logic             Fall,
    output logic             Pending,
    output logic             Err
);

    localparam logic [WIDTH-1:0] c_DEFAULT_HALF = WIDTH'(DEFAULT_HALF);
    localparam logic [WIDTH-1:0] c_ONE          = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] r_cnt;
    logic             r_pending;
    logic             r_clk_out;
    logic             r_rise;
    logic             r_fall;
    logic             r_err;

    logic             w_running;
    logic             w_tick;
    logic             w_boundary;
    logic             w_load_ok;
    logic             w_load_bad;

    assign w_running  = (r_state != S_IDLE);
    assign w_tick     = w_running && (r_cnt == (r_active - c_ONE));
    // The falling toggle is the period boundary where divisors are swapped.
    assign w_boundary = w_tick && r_clk_out;
    assign w_load_ok  = Load && (Half_in != '0);
    assign w_load_bad = Load && (Half_in == '0);

    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (En) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!En) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (En) begin
                    w_state_nxt = S_RUN;
                end else if (w_boundary) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_err     <= 1'b0;
            r_active  <= c_DEFAULT_HALF;
            r_pend    <= '0;
            r_pending <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_err  <= w_load_bad;

            if (w_running) begin
                if (w_tick) begin
                    r_cnt     <= '0;
                    r_clk_out <= ~r_clk_out;
                    r_rise    <= ~r_clk_out;
                    r_fall    <= r_clk_out;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end else begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
            end

            // A load landing on the boundary edge beats any queued value.
            if (!w_running) begin
                if (w_load_ok) begin
                    r_active <= Half_in;
                end
            end else if (w_boundary) begin
                if (w_load_ok) begin
                    r_active <= Half_in;
                end else if (r_pending) begin
                    r_active <= r_pend;
                end
                r_pending <= 1'b0;
            end else if (w_load_ok) begin
                r_pend    <= Half_in;
                r_pending <= 1'b1;
            end
        end
    end

    assign Clk_out = r_clk_out;
    assign Rise    = r_rise;
    assign Fall    = r_fall;
    assign Pending = r_pending;
    assign Err     = r_err;

endmodule

`default_nettype wire
